// File: rtl/mult_arbiter_pkg.sv
// mult_arbiter_pkg: state encoding, default timeout and index-width helper
// shared by the multiplier arbiter and its round-robin picker.
package mult_arbiter_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int TIMEOUT_DEF = 64;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_arbiter_rr_picker.sv
// rr_picker: combinational round-robin select; the search starts just after
// the last owner so that owner ends up with the lowest priority.
module rr_picker
    import mult_arbiter_pkg::*;
#(
    parameter  int N_REQ = 2,
    localparam int IW    = idx_w(N_REQ)
)(
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    logic [IW-1:0] j;

    // Walk from farthest to nearest so the nearest requester wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = IW'((int'(last) + k) % N_REQ);
            if (req[j]) begin
                valid = 1'b1;
                idx   = j;
            end
        end
    end

    assign gnt = valid ? ({{(N_REQ-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one sequential multiplier among N_REQ
// requesters. Optional WAIT timeout is enabled by defining MULTARB_TIMEOUT_EN.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int W       = 8,
    parameter int TIMEOUT = TIMEOUT_DEF
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [2*W-1:0]     rsp_p,
    output logic               rsp_err,
    output logic               arb_busy,
    output logic               m_start,
    output logic [W-1:0]       m_a,
    output logic [W-1:0]       m_b,
    input  logic [2*W-1:0]     m_p,
    input  logic               m_done
);

    localparam int IW = idx_w(N_REQ);

    if (N_REQ < 2 || N_REQ > 4 || TIMEOUT < 1) begin : g_bad_params
        $error("mult_arbiter: N_REQ must be 2..4 and TIMEOUT positive");
    end

    logic [1:0]       state, state_n;
    logic [IW-1:0]    owner, last, win_idx;
    logic [N_REQ-1:0] win_gnt;
    logic             win_valid;
    logic             tmo;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req   (req),
        .last  (last),
        .gnt   (win_gnt),
        .idx   (win_idx),
        .valid (win_valid)
    );

    always_comb begin
        state_n = (state == S_IDLE)  ? (win_valid ? S_ISSUE : S_IDLE) :
                  (state == S_ISSUE) ? S_WAIT :
                  (state == S_WAIT)  ? ((m_done || tmo) ? S_RESP : S_WAIT) :
                                       S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            owner     <= '0;
            last      <= IW'(N_REQ - 1);
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_p     <= '0;
            m_start   <= 1'b0;
            m_a       <= '0;
            m_b       <= '0;
            arb_busy  <= 1'b0;
        end else begin
            state     <= state_n;
            arb_busy  <= (state_n != S_IDLE);
            gnt       <= '0;
            rsp_valid <= '0;
            m_start   <= 1'b0;
            if (state == S_IDLE && win_valid) begin
                owner   <= win_idx;
                gnt     <= win_gnt;
                m_start <= 1'b1;
                m_a     <= req_a[win_idx*W +: W];
                m_b     <= req_b[win_idx*W +: W];
            end
            // A real done in the timeout cycle still delivers the product.
            if (state == S_WAIT && (m_done || tmo)) begin
                rsp_p     <= m_done ? m_p : '0;
                rsp_valid <= {{(N_REQ-1){1'b0}}, 1'b1} << owner;
            end
            if (state == S_RESP)
                last <= owner;
        end
    end

`ifdef MULTARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] cnt;

    assign tmo = (state == S_WAIT) && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            rsp_err <= 1'b0;
        end else begin
            cnt <= (state == S_WAIT) ? cnt + 1'b1 : '0;
            if (state == S_IDLE && win_valid)
                rsp_err <= 1'b0;
            else if (tmo && !m_done)
                rsp_err <= 1'b1;
        end
    end
`else
    assign tmo     = 1'b0;
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized phase scored against a transaction-level round-robin model.
module tb_mult_arbiter;

    localparam int N  = 2;
    localparam int W  = 8;
    localparam int TO = 16;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   gnt, rsp_valid;
    logic [2*W-1:0] rsp_p;
    logic           rsp_err, arb_busy, m_start;
    logic [W-1:0]   m_a, m_b;
    logic [2*W-1:0] m_p;
    logic           m_done;

    mult_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_p(rsp_p), .rsp_err(rsp_err),
        .arb_busy(arb_busy), .m_start(m_start), .m_a(m_a), .m_b(m_b),
        .m_p(m_p), .m_done(m_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Multiplier model: product appears with done mul_lat cycles after m_start.
    logic           mdone, stray, mul_en;
    logic [2*W-1:0] mprod;
    int             mcnt, mul_lat;

    always @(posedge clk) begin
        if (reset) begin
            mcnt  <= 0;
            mdone <= 1'b0;
        end else begin
            mdone <= 1'b0;
            if (m_start && mul_en) begin
                mcnt  <= mul_lat - 1;
                mprod <= m_a * m_b;
            end else if (mcnt > 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1) mdone <= 1'b1;
            end
        end
    end

    assign m_done = mdone | stray;
    assign m_p    = mprod;

    always @(negedge clk) begin
        if (!reset) begin
            check("gnt_onehot", 32'($countones(gnt) <= 1), 1);
            check("rsp_onehot", 32'($countones(rsp_valid) <= 1), 1);
        end
    end

    // Transaction-level reference for the random phase.
    logic           mon_en;
    logic [N-1:0]   prev_req;
    logic [N*W-1:0] prev_a, prev_b;
    int             q_idx[$], q_p[$];
    int             m_last, e_idx, g_idx, o_idx, o_p, n_grants;
    int             wait_cnt[N];

    function automatic int pick(input logic [N-1:0] r, input int lst);
        for (int k = 1; k <= N; k++)
            if (r[(lst + k) % N]) return (lst + k) % N;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (gnt != 0) begin
                n_grants++;
                g_idx = $clog2(gnt);
                e_idx = pick(prev_req, m_last);
                check("rr_order", g_idx, e_idx);
                check("rand_m_a", m_a, prev_a[g_idx*W +: W]);
                check("rand_m_b", m_b, prev_b[g_idx*W +: W]);
                q_idx.push_back(g_idx);
                q_p.push_back(int'(prev_a[g_idx*W +: W]) * int'(prev_b[g_idx*W +: W]));
                for (int i = 0; i < N; i++) begin
                    if (i != g_idx && prev_req[i]) begin
                        wait_cnt[i]++;
                        check("wait_bound", 32'(wait_cnt[i] <= N - 1), 1);
                    end
                end
                wait_cnt[g_idx] = 0;
            end
            if (rsp_valid != 0) begin
                if (q_idx.size() == 0) begin
                    check("rsp_expected", 0, 1);
                end else begin
                    o_idx = q_idx.pop_front();
                    o_p   = q_p.pop_front();
                    check("rand_rsp_valid", rsp_valid, 1 << o_idx);
                    check("rand_rsp_p", rsp_p, o_p);
                    check("rand_rsp_err", rsp_err, 0);
                    m_last = o_idx;
                end
            end
        end
        prev_req = req;
        prev_a   = req_a;
        prev_b   = req_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        stray = 1'b0;
        repeat (2) tick();
        check("reset_ctl", {gnt, rsp_valid, rsp_err, m_start, arb_busy}, 0);
        check("reset_data", {m_a, m_b, rsp_p}, 0);
        reset = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (rsp_valid == 0 && n < 40);
    endtask

    task automatic run_single(input int r, input logic [7:0] a, input logic [7:0] b,
                              input logic [15:0] p);
        int n;
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
        req[r] = 1'b1;
        tick();
        check("gnt", gnt, 1 << r);
        check("m_start", m_start, 1);
        check("m_a", m_a, a);
        check("m_b", m_b, b);
        check("busy_issue", arb_busy, 1);
        check("err_clear", rsp_err, 0);
        req[r] = 1'b0;
        wait_rsp(n);
        check("rsp_latency", n, 9);
        check("rsp_valid", rsp_valid, 1 << r);
        check("rsp_p", rsp_p, p);
        check("rsp_err", rsp_err, 0);
        check("m_a_hold", m_a, a);
        tick();
        check("rsp_pulse", rsp_valid, 0);
        check("busy_idle", arb_busy, 0);
    endtask

    typedef struct {
        int          r;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t tbl[7];
    int   seq[$];
    int   n, t;

    initial begin
        tbl[0] = '{0, 8'd12,  8'd11,  16'd132};
        tbl[1] = '{1, 8'd7,   8'd9,   16'd63};
        tbl[2] = '{0, 8'd255, 8'd255, 16'd65025};
        tbl[3] = '{1, 8'd3,   8'd4,   16'd12};
        tbl[4] = '{0, 8'd0,   8'd200, 16'd0};
        tbl[5] = '{1, 8'd1,   8'd255, 16'd255};
        tbl[6] = '{0, 8'd128, 8'd2,   16'd256};

        reset = 1'b1; req = '0; req_a = '0; req_b = '0;
        stray = 1'b0; mul_en = 1'b1; mul_lat = 8; mon_en = 1'b0; n_grants = 0;
        do_reset();

        foreach (tbl[i]) run_single(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].p);

        // Simultaneous requests right after reset: requester 0 goes first.
        do_reset();
        req_a = {8'd255, 8'd7};
        req_b = {8'd255, 8'd9};
        req   = 2'b11;
        tick();
        check("sim_gnt0", gnt, 2'b01);
        req[0] = 1'b0;
        wait_rsp(n);
        check("sim_lat0", n, 9);
        check("sim_rsp0", rsp_valid, 2'b01);
        check("sim_p0", rsp_p, 63);
        tick();
        check("sim_idle_gap", gnt, 0);
        tick();
        check("sim_gnt1", gnt, 2'b10);
        check("sim_m_a1", m_a, 255);
        req[1] = 1'b0;
        wait_rsp(n);
        check("sim_lat1", n, 9);
        check("sim_rsp1", rsp_valid, 2'b10);
        check("sim_p1", rsp_p, 65025);
        tick();

        // Fairness: both requesters held high for six transactions.
        do_reset();
        req_a = {8'd200, 8'd5};
        req_b = {8'd3,   8'd6};
        req   = 2'b11;
        seq.delete();
        t = 0;
        while (seq.size() < 6 && t < 200) begin
            tick();
            t++;
            if (gnt != 0) seq.push_back($clog2(gnt));
            if (rsp_valid != 0)
                check("fair_p", rsp_p, rsp_valid[0] ? 30 : 600);
        end
        check("fair_count", seq.size(), 6);
        foreach (seq[k]) check("fair_alt", seq[k], k % 2);
        req = '0;
        repeat (20) tick();

        // Reset in the middle of WAIT, with requester 1 waiting through it.
        do_reset();
        req_a = {8'd3, 8'd50};
        req_b = {8'd4, 8'd50};
        req   = 2'b01;
        tick();
        check("rst_gnt0", gnt, 2'b01);
        req = 2'b00;
        repeat (4) tick();
        reset = 1'b1;
        req   = 2'b10;
        tick();
        check("rst_mid_ctl", {gnt, rsp_valid, rsp_err, m_start, arb_busy}, 0);
        check("rst_mid_data", {m_a, m_b, rsp_p}, 0);
        reset = 1'b0;
        tick();
        check("rst_gnt1", gnt, 2'b10);
        check("rst_m_a", m_a, 3);
        req = 2'b00;
        wait_rsp(n);
        check("rst_lat", n, 9);
        check("rst_rsp", rsp_valid, 2'b10);
        check("rst_p", rsp_p, 12);
        tick();

        // Stray done pulses in IDLE and ISSUE are ignored.
        stray = 1'b1;
        tick();
        stray = 1'b0;
        check("stray_idle_rsp", rsp_valid, 0);
        check("stray_idle_busy", arb_busy, 0);
        req_a[7:0] = 8'd9;
        req_b[7:0] = 8'd9;
        req = 2'b01;
        tick();
        check("stray_gnt", gnt, 2'b01);
        stray = 1'b1;
        req   = 2'b00;
        tick();
        stray = 1'b0;
        check("stray_issue_rsp", rsp_valid, 0);
        check("stray_issue_busy", arb_busy, 1);
        wait_rsp(n);
        check("stray_lat", n, 8);
        check("stray_p", rsp_p, 81);
        tick();

`ifdef MULTARB_TIMEOUT_EN
        mul_en = 1'b0;
        req_a[7:0] = 8'd10;
        req_b[7:0] = 8'd10;
        req = 2'b01;
        tick();
        check("tmo_gnt", gnt, 2'b01);
        req = 2'b00;
        wait_rsp(n);
        check("tmo_lat", n, 17);
        check("tmo_rsp", rsp_valid, 2'b01);
        check("tmo_err", rsp_err, 1);
        check("tmo_p", rsp_p, 0);
        tick();
        mul_en = 1'b1;
        run_single(1, 8'd6, 8'd7, 16'd42);
`endif

        // Randomized traffic with random multiplier latency.
        do_reset();
        m_last   = N - 1;
        prev_req = '0;
        q_idx.delete();
        q_p.delete();
        foreach (wait_cnt[i]) wait_cnt[i] = 0;
        n_grants = 0;
        mon_en   = 1'b1;
        for (int c = 0; c < 800; c++) begin
            tick();
            mul_lat = $urandom_range(2, 10);
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (gnt[i]) begin
                        if ($urandom_range(0, 1) == 0) begin
                            req[i] = 1'b0;
                        end else begin
                            req_a[i*W +: W] = W'($urandom);
                            req_b[i*W +: W] = W'($urandom);
                        end
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    req_a[i*W +: W] = W'($urandom);
                    req_b[i*W +: W] = W'($urandom);
                    req[i] = 1'b1;
                end
            end
        end
        req = '0;
        t = 0;
        while ((arb_busy || q_idx.size() != 0) && t < 60) begin
            tick();
            t++;
        end
        @(negedge clk);
        mon_en = 1'b0;
        check("rand_drain", q_idx.size(), 0);
        check("rand_idle", arb_busy, 0);
        check("rand_activity", 32'(n_grants >= 20), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
